mult_share_arbiter: RTL

- Shares one pipelined vedic 16x16 multiplier (do/done handshake, fixed latency) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- An in-flight tag FIFO routes each multiplier result back to its originating requester.
- Sits between the matrix-multiply PE request ports and the single multiplier instance.

---
 rtl/mult_share_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined 16x16 multiplier between NUM_REQ requesters.
// A tag FIFO routes products back to their requesters in issue order. Define MULT_ARB_STATS_EN to add the counters.
module mult_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    output logic                    mul_do,
    input  logic [31:0]             mul_result,
    input  logic                    mul_done,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy,
    output logic                    err_underflow,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_stall
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] ign_cnt;
    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic             full, empty, pop, accept;
    logic [ID_W-1:0]  head_id;
    int               idx;

    assign full    = (count == CNT_W'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign pop     = mul_done && !empty;
    assign accept  = grant_found && (!full || pop);
    assign head_id = tag_mem[rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign req_ready = (accept && reset) ? (NUM_REQ'(1) << grant_id) : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_a         <= '0;
            mul_b         <= '0;
            mul_do        <= 1'b0;
            resp_valid    <= '0;
            resp_data     <= '0;
            resp_id       <= '0;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
            rr_ptr        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ign_cnt       <= CNT_W'(TAG_DEPTH);
        end else begin
            mul_do <= accept;
            if (accept) begin
                mul_a  <= req_a[16*grant_id +: 16];
                mul_b  <= req_b[16*grant_id +: 16];
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end

            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                resp_valid <= NUM_REQ'(1) << head_id;
                resp_data  <= mul_result;
                resp_id    <= head_id;
            end else begin
                resp_valid <= '0;
            end

            count <= count_next;
            busy  <= (count_next != '0);

            // Done pulses from operations killed by reset land in this window; drop them quietly.
            if (ign_cnt != '0)
                ign_cnt <= ign_cnt - 1'b1;
            if (mul_done && empty && ign_cnt == '0)
                err_underflow <= 1'b1;
        end
    end

    // NOTE: the tag storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && accept)
            tag_mem[wr_ptr] <= grant_id;
    end

`ifdef MULT_ARB_STATS_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept && issued_q != 32'hFFFF_FFFF)
                issued_q <= issued_q + 1'b1;
            if (|req_valid && !accept && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule
